// File: rtl/haze_frame_sched_if.sv
// Bus between the camera/config side and the frame scheduler.
// Carries config writes, raw and gated frame timing, datapath completion and status.
interface haze_frame_sched_if;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        pre_frame_vsync;
  logic        pre_frame_href;
  logic        pre_frame_clken;
  logic [23:0] pre_img;
  logic        dp_frame_vsync;
  logic        dp_frame_href;
  logic        dp_frame_clken;
  logic [23:0] dp_img;
  logic        post_frame_vsync;
  logic        act_bypass;
  logic [7:0]  act_omega;
  logic [7:0]  act_t0;
  logic [2:0]  inflight;
  logic [15:0] frame_in_cnt;
  logic [15:0] frame_drop_cnt;
  logic        geom_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata,
    output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img,
    output post_frame_vsync,
    input  dp_frame_vsync, dp_frame_href, dp_frame_clken, dp_img,
    input  act_bypass, act_omega, act_t0,
    input  inflight, frame_in_cnt, frame_drop_cnt, geom_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata,
    input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img,
    input  post_frame_vsync,
    output dp_frame_vsync, dp_frame_href, dp_frame_clken, dp_img,
    output act_bypass, act_omega, act_t0,
    output inflight, frame_in_cnt, frame_drop_cnt, geom_err
  );
endinterface

// File: rtl/haze_frame_sched.sv
// Frame scheduler ahead of the dehaze datapath: admits/drops whole frames to bound
// pipeline occupancy, commits shadow config at admitted frame starts, checks geometry.
//
// state    | meaning
// S_IDLE   | scheduler disabled, nothing forwarded
// S_ACCEPT | current frame admitted, timing/pixels forwarded with 1-clk latency
// S_DROP   | current frame dropped because the pipeline is full
module haze_frame_sched #(
  parameter int IMG_HDISP    = 640,
  parameter int IMG_VDISP    = 480,
  parameter int MAX_INFLIGHT = 2
) (
  input logic               clk,
  input logic               rst,
  haze_frame_sched_if.slave bus_io
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_q, href_q, post_vsync_q;
  logic        enable_q, bypass_sh_q;
  logic [7:0]  omega_sh_q, t0_sh_q;
  logic        act_bypass_q;
  logic [7:0]  act_omega_q, act_t0_q;
  logic [2:0]  inflight_q;
  logic [15:0] in_cnt_q, drop_cnt_q;
  logic [15:0] pix_cnt_q, line_cnt_q;
  logic        geom_err_q;
  logic        dp_vsync_q, dp_href_q, dp_clken_q;
  logic [23:0] dp_img_q;

  logic fs, href_rise, href_fall, post_fall, full, clear, dec;
  logic accept, drop_evt, fwd, pix_err, line_err;
  logic unused_wdata_hi;

  assign fs        = bus_io.pre_frame_vsync & ~vsync_q;
  assign href_rise = bus_io.pre_frame_href & ~href_q;
  assign href_fall = ~bus_io.pre_frame_href & href_q;
  assign post_fall = post_vsync_q & ~bus_io.post_frame_vsync;
  assign full      = (inflight_q == 3'(MAX_INFLIGHT));
  assign clear     = bus_io.cfg_wr && (bus_io.cfg_addr == 2'd3);
  assign dec       = post_fall && (inflight_q != 3'd0);
  assign unused_wdata_hi = ^bus_io.cfg_wdata[15:8];

  // vsync history resets high so a vsync already high at reset release is not taken as a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      post_vsync_q <= 1'b0;
    end else begin
      vsync_q      <= bus_io.pre_frame_vsync;
      href_q       <= bus_io.pre_frame_href;
      post_vsync_q <= bus_io.post_frame_vsync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fs) begin
      if (!enable_q)  state_d = S_IDLE;
      else if (full)  state_d = S_DROP;
      else            state_d = S_ACCEPT;
    end
  end

  always_comb begin
    accept   = 1'b0;
    drop_evt = 1'b0;
    if (fs && enable_q) begin
      if (full) drop_evt = 1'b1;
      else      accept   = 1'b1;
    end
    fwd = (state_d == S_ACCEPT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q    <= 1'b0;
      bypass_sh_q <= 1'b0;
      omega_sh_q  <= 8'hF2;
      t0_sh_q     <= 8'h1A;
    end else if (bus_io.cfg_wr) begin
      case (bus_io.cfg_addr)
        2'd0: begin
          enable_q    <= bus_io.cfg_wdata[0];
          bypass_sh_q <= bus_io.cfg_wdata[1];
        end
        2'd1:    omega_sh_q <= bus_io.cfg_wdata[7:0];
        2'd2:    t0_sh_q    <= bus_io.cfg_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_bypass_q <= 1'b0;
      act_omega_q  <= 8'hF2;
      act_t0_q     <= 8'h1A;
    end else if (accept) begin
      act_bypass_q <= bypass_sh_q;
      act_omega_q  <= omega_sh_q;
      act_t0_q     <= t0_sh_q;
    end
  end

  // admission decision uses the pre-decrement count, so a simultaneous completion cannot rescue a full slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  inflight_q <= 3'd0;
    else if (accept && !dec)  inflight_q <= inflight_q + 3'd1;
    else if (dec && !accept)  inflight_q <= inflight_q - 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q   <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      if (clear)       in_cnt_q <= 16'd0;
      else if (accept) in_cnt_q <= in_cnt_q + 16'd1;
      if (clear)                                    drop_cnt_q <= 16'd0;
      else if (drop_evt && drop_cnt_q != 16'hFFFF)  drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_vsync_q <= 1'b0;
      dp_href_q  <= 1'b0;
      dp_clken_q <= 1'b0;
      dp_img_q   <= 24'd0;
    end else if (fwd) begin
      dp_vsync_q <= bus_io.pre_frame_vsync;
      dp_href_q  <= bus_io.pre_frame_href;
      dp_clken_q <= bus_io.pre_frame_clken;
      dp_img_q   <= bus_io.pre_img;
    end else begin
      dp_vsync_q <= 1'b0;
      dp_href_q  <= 1'b0;
      dp_clken_q <= 1'b0;
    end
  end

  assign pix_err  = (state_q == S_ACCEPT) && href_fall && (pix_cnt_q != 16'(IMG_HDISP));
  assign line_err = (state_q == S_ACCEPT) && fs && (line_cnt_q != 16'(IMG_VDISP));

  // counters saturate so an oversized line/frame can never alias back to the expected size
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q  <= 16'd0;
      line_cnt_q <= 16'd0;
      geom_err_q <= 1'b0;
    end else begin
      if (href_rise)
        pix_cnt_q <= {15'd0, bus_io.pre_frame_clken};
      else if (bus_io.pre_frame_href && bus_io.pre_frame_clken && pix_cnt_q != 16'hFFFF)
        pix_cnt_q <= pix_cnt_q + 16'd1;
      if (fs)
        line_cnt_q <= 16'd0;
      else if (href_fall && line_cnt_q != 16'hFFFF)
        line_cnt_q <= line_cnt_q + 16'd1;
      if (clear)                    geom_err_q <= 1'b0;
      else if (pix_err || line_err) geom_err_q <= 1'b1;
    end
  end

  assign bus_io.dp_frame_vsync = dp_vsync_q;
  assign bus_io.dp_frame_href  = dp_href_q;
  assign bus_io.dp_frame_clken = dp_clken_q;
  assign bus_io.dp_img         = dp_img_q;
  assign bus_io.act_bypass     = act_bypass_q;
  assign bus_io.act_omega      = act_omega_q;
  assign bus_io.act_t0         = act_t0_q;
  assign bus_io.inflight       = inflight_q;
  assign bus_io.frame_in_cnt   = in_cnt_q;
  assign bus_io.frame_drop_cnt = drop_cnt_q;
  assign bus_io.geom_err       = geom_err_q;

endmodule

// File: tb/tb_haze_frame_sched.sv
// Directed bench for haze_frame_sched using a small frame geometry (4x2) and two in-flight slots.
module tb_haze_frame_sched;
  localparam int H = 4;
  localparam int V = 2;
  localparam int M = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  haze_frame_sched_if bus ();

  haze_frame_sched #(.IMG_HDISP(H), .IMG_VDISP(V), .MAX_INFLIGHT(M)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    logic        eb;
    logic [7:0]  eo;
    logic [7:0]  et;
  } cfg_vec_t;

  int          errors = 0;
  int          checks = 0;
  int          frame_bad = 0;
  int          fcount = 0;
  logic        exp_fwd = 1'b0;
  logic [23:0] eimg = 24'd0;
  logic [7:0]  omega_at_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, check registered dp outputs at the next negedge
  task automatic cyc(input logic vs, input logic hr, input logic ck, input logic [23:0] px);
    logic [2:0] ectl;
    bus.pre_frame_vsync = vs;
    bus.pre_frame_href  = hr;
    bus.pre_frame_clken = ck;
    bus.pre_img         = px;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    if (exp_fwd) begin
      ectl = {vs, hr, ck};
      eimg = px;
    end else begin
      ectl = 3'b000;
    end
    if ({bus.dp_frame_vsync, bus.dp_frame_href, bus.dp_frame_clken} !== ectl || bus.dp_img !== eimg)
      frame_bad++;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic cfg_set(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d);
    cfg_set(a, d);
    idle();
  endtask

  task automatic post_pulse();
    bus.post_frame_vsync = 1'b1;
    idle();
    bus.post_frame_vsync = 1'b0;
    idle();
  endtask

  task automatic frame(input int lines, input int short_pix, input logic fwd, input logic do_wr,
                       input logic wr_at_fs, input logic [1:0] wa, input logic [15:0] wd);
    frame_bad = 0;
    exp_fwd = fwd;
    fcount++;
    bus.post_frame_vsync = 1'b0;
    if (do_wr && wr_at_fs) cfg_set(wa, wd);
    cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    omega_at_fs = bus.act_omega;
    cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    idle();
    for (int l = 0; l < lines; l++) begin
      int np;
      np = (l == 0) ? H - short_pix : H;
      for (int p = 0; p < np; p++) begin
        if (p == 2) cyc(1'b0, 1'b1, 1'b0, 24'($urandom));
        if (do_wr && !wr_at_fs && l == 0 && p == 1) cfg_set(wa, wd);
        cyc(1'b0, 1'b1, 1'b1, {8'(fcount), 8'(l), 8'(p)});
      end
      idle();
      idle();
    end
    chk("frame_gating", frame_bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_vec_t tbl[4];
    logic [7:0] po, pt;
    logic       pb;

    tbl[0] = '{addr: 2'd0, data: 16'h0003, eb: 1'b1, eo: 8'hC0, et: 8'h1A};
    tbl[1] = '{addr: 2'd1, data: 16'hAB55, eb: 1'b1, eo: 8'h55, et: 8'h1A};
    tbl[2] = '{addr: 2'd2, data: 16'h0107, eb: 1'b1, eo: 8'h55, et: 8'h07};
    tbl[3] = '{addr: 2'd0, data: 16'h0001, eb: 1'b0, eo: 8'h55, et: 8'h07};

    rst = 1'b1;
    bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'd0;
    bus.pre_frame_vsync = 1'b0; bus.pre_frame_href = 1'b0; bus.pre_frame_clken = 1'b0;
    bus.pre_img = 24'd0; bus.post_frame_vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dp_ctl", {29'd0, bus.dp_frame_vsync, bus.dp_frame_href, bus.dp_frame_clken}, 0);
    chk("rst_dp_img", bus.dp_img, 0);
    chk("rst_omega", bus.act_omega, 8'hF2);
    chk("rst_t0", bus.act_t0, 8'h1A);
    chk("rst_bypass", bus.act_bypass, 0);
    chk("rst_status", {bus.inflight, bus.geom_err, bus.frame_in_cnt, 12'(bus.frame_drop_cnt)}, 0);
    rst = 1'b0;

    // three frames, no completions; omega rewritten mid frame 1
    cfg(2'd0, 16'h0001);
    frame(V, 0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h00C0);
    chk("omega_hold_f1", bus.act_omega, 8'hF2);
    frame(V, 0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("omega_commit_f2", omega_at_fs, 8'hC0);
    frame(V, 0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("t1_inflight", bus.inflight, 2);
    chk("t1_in_cnt", bus.frame_in_cnt, 2);
    chk("t1_drop_cnt", bus.frame_drop_cnt, 1);
    chk("t1_geom", bus.geom_err, 0);

    // completion falling edge coincides with the FS of a frame meeting a full pipeline
    bus.post_frame_vsync = 1'b1;
    idle();
    frame(V, 0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("t2_inflight", bus.inflight, 1);
    chk("t2_drop_cnt", bus.frame_drop_cnt, 2);
    frame(V, 0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("t2_in_cnt", bus.frame_in_cnt, 3);
    chk("t2_inflight_full", bus.inflight, 2);
    post_pulse();
    post_pulse();
    post_pulse();
    chk("dec_floor", bus.inflight, 0);

    // shadow config commit table
    pb = 1'b0; po = 8'hC0; pt = 8'h1A;
    for (int i = 0; i < 4; i++) begin
      cfg(tbl[i].addr, tbl[i].data);
      chk("cfg_no_early", {15'd0, bus.act_bypass, bus.act_omega, bus.act_t0}, {15'd0, pb, po, pt});
      frame(V, 0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      chk("cfg_commit", {15'd0, bus.act_bypass, bus.act_omega, bus.act_t0},
          {15'd0, tbl[i].eb, tbl[i].eo, tbl[i].et});
      chk("cfg_in_cnt", bus.frame_in_cnt, 32'(4 + i));
      post_pulse();
      pb = tbl[i].eb; po = tbl[i].eo; pt = tbl[i].et;
    end

    // short line
    frame(V, 1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("short_line_err", bus.geom_err, 1);
    post_pulse();
    cfg(2'd3, 16'h0000);
    chk("clear_geom", bus.geom_err, 0);
    chk("clear_cnts", {bus.frame_in_cnt, bus.frame_drop_cnt}, 0);

    // short frame admitted, then short frame dropped
    frame(1, 0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("short_frame_no_err_yet", bus.geom_err, 0);
    frame(V, 0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("short_frame_err", bus.geom_err, 1);
    cfg(2'd3, 16'h0000);
    frame(1, 0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("drop_short_cnt", bus.frame_drop_cnt, 1);
    post_pulse();
    frame(V, 0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("drop_short_no_err", bus.geom_err, 0);
    chk("drop_short_in_cnt", bus.frame_in_cnt, 1);
    post_pulse();
    post_pulse();
    chk("pre_rst_inflight", bus.inflight, 0);

    // reset mid-line of an admitted frame
    frame_bad = 0;
    exp_fwd = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    idle();
    cyc(1'b0, 1'b1, 1'b1, 24'h111111);
    cyc(1'b0, 1'b1, 1'b1, 24'h222222);
    chk("pre_rst_fwd", frame_bad, 0);
    chk("pre_rst_admit", bus.inflight, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_dp", {29'd0, bus.dp_frame_vsync, bus.dp_frame_href, bus.dp_frame_clken}, 0);
    frame_bad = 0;
    for (int k = 0; k < 3; k++) begin
      bus.pre_img = 24'($urandom);
      @(negedge clk);
      if ({bus.dp_frame_vsync, bus.dp_frame_href, bus.dp_frame_clken} !== 3'b000 ||
          bus.dp_img !== 24'd0 || bus.inflight !== 3'd0)
        frame_bad++;
    end
    chk("rst_hold_dp", frame_bad, 0);
    rst = 1'b0;
    exp_fwd = 1'b0;
    eimg = 24'd0;
    frame_bad = 0;
    cfg_set(2'd0, 16'h0001);
    cyc(1'b0, 1'b1, 1'b1, 24'h333333);
    cyc(1'b0, 1'b1, 1'b1, 24'h444444);
    idle();
    idle();
    for (int p = 0; p < H; p++) cyc(1'b0, 1'b1, 1'b1, 24'($urandom));
    idle();
    idle();
    chk("post_rst_gated", frame_bad, 0);
    chk("post_rst_inflight", bus.inflight, 0);

    // next full FS restarts forwarding; a CLEAR at that FS beats the increment
    frame(V, 0, 1'b1, 1'b1, 1'b1, 2'd3, 16'h0000);
    chk("restart_inflight", bus.inflight, 1);
    chk("clear_wins_in_cnt", bus.frame_in_cnt, 0);
    chk("restart_geom", bus.geom_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
